// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: turns one cacheline request from the memory arbiter into
// a BEATS-long burst on the physical memory port (and assembles read bursts
// back into a line). One transaction in flight; completion is a one-cycle resp_o.
// Every output is either a register or a decode of registered state.

module line_burst_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_next_state;
    logic   [CNT_W-1:0]             r_cnt;
    logic   [ADDR_WIDTH-OFFSET_W-1:0] r_line_addr;
    logic   [LINE_WIDTH-1:0]        r_line_wr;
    logic   [LINE_WIDTH-1:0]        r_line_rd;
    logic                           w_last_beat;
    logic   [BURST_WIDTH-1:0]       w_wr_beat;
    logic   [OFFSET_W-1:0]          w_unused_addr_bits;

    // Byte offset within the line is dropped: the memory port always sees aligned addresses.
    assign w_unused_addr_bits = address_i[OFFSET_W-1:0];

    assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));
    assign w_wr_beat   = r_line_wr[int'(r_cnt) * BURST_WIDTH +: BURST_WIDTH];

    // Output decode from registered state only; no input reaches an output combinationally.
    assign read_o    = (r_state == ST_READ);
    assign write_o   = (r_state == ST_WRITE);
    assign resp_o    = (r_state == ST_DONE);
    assign burst_o   = (r_state == ST_WRITE) ? w_wr_beat : {BURST_WIDTH{1'b0}};
    assign address_o = {r_line_addr, {OFFSET_W{1'b0}}};
    assign line_o    = r_line_rd;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; read wins when both requests are (illegally) high.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (read_i) begin
                    w_next_state = ST_READ;
                end else if (write_i) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ: begin
                if (resp_i && w_last_beat) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_READ;
                end
            end
            ST_WRITE: begin
                if (resp_i && w_last_beat) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch request in IDLE, count beats and capture/consume data in READ/WRITE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= {CNT_W{1'b0}};
            r_line_addr <= {(ADDR_WIDTH-OFFSET_W){1'b0}};
            r_line_wr   <= {LINE_WIDTH{1'b0}};
            r_line_rd   <= {LINE_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= {CNT_W{1'b0}};
                    if (read_i) begin
                        r_line_addr <= address_i[ADDR_WIDTH-1:OFFSET_W];
                    end else if (write_i) begin
                        r_line_addr <= address_i[ADDR_WIDTH-1:OFFSET_W];
                        r_line_wr   <= line_i;
                    end else begin
                        r_line_addr <= r_line_addr;
                    end
                end
                ST_READ: begin
                    if (resp_i) begin
                        r_line_rd[int'(r_cnt) * BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                ST_WRITE: begin
                    if (resp_i) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                ST_DONE: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed, table-driven bench for line_burst_adaptor plus hand-written
// sequences for stalls, asynchronous reset mid-burst and back-to-back requests.

module tb_line_burst_adaptor;

    logic         clk;
    logic         reset_n;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int errors = 0;
    int checks = 0;
    bit illegal_seen = 1'b0;

    line_burst_adaptor #(.LINE_WIDTH(256), .BURST_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag the illegal upstream combination of simultaneous read and write requests.
    always @(posedge clk) begin
        if (read_i && write_i) begin
            illegal_seen <= 1'b1;
            $display("note: read_i and write_i both high at %0t", $time);
        end
    end

    typedef struct {
        logic         rd, wr, rsp;
        logic [31:0]  addr;
        logic [63:0]  beat;
        logic [255:0] line;
        logic         e_rd, e_wr, e_rsp;
        logic [31:0]  e_addr;
        logic [63:0]  e_burst;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic rsp,
                                input logic [31:0] addr, input logic [63:0] beat,
                                input logic [255:0] line, input logic e_rd, input logic e_wr,
                                input logic e_rsp, input logic [31:0] e_addr,
                                input logic [63:0] e_burst);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rsp = rsp; v.addr = addr; v.beat = beat; v.line = line;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_rsp = e_rsp; v.e_addr = e_addr; v.e_burst = e_burst;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ports(input string tag, input logic e_rd, input logic e_wr,
                               input logic e_rsp, input logic [31:0] e_addr,
                               input logic [63:0] e_burst);
        check({tag, "_read_o"},    {255'd0, read_o},  {255'd0, e_rd});
        check({tag, "_write_o"},   {255'd0, write_o}, {255'd0, e_wr});
        check({tag, "_resp_o"},    {255'd0, resp_o},  {255'd0, e_rsp});
        check({tag, "_address_o"}, {224'd0, address_o}, {224'd0, e_addr});
        check({tag, "_burst_o"},   {192'd0, burst_o}, {192'd0, e_burst});
    endtask

    logic [255:0] wline;
    logic [255:0] wline2;
    logic [63:0]  stall_beats[4];
    int           stall_pat[7];
    int           pulses;
    int           k_beat;
    logic         prev_resp;

    initial begin
        wline  = {rep(8'hDD), rep(8'hCC), rep(8'hBB), rep(8'hAA)};
        wline2 = {rep(8'h04), rep(8'h03), rep(8'h02), rep(8'h01)};
        stall_beats = '{rep(8'h55), rep(8'h66), rep(8'h77), rep(8'h88)};
        stall_pat   = '{1, 0, 0, 1, 0, 1, 1};

        // Read burst rows (address 0x1234 -> 0x1220), then write burst rows (0xABCD -> 0xABC0).
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0000_1234, 64'd0,       256'd0, 1'b1, 1'b0, 1'b0, 32'h0000_1220, 64'd0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_1234, rep(8'h11),  256'd0, 1'b1, 1'b0, 1'b0, 32'h0000_1220, 64'd0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_1234, rep(8'h22),  256'd0, 1'b1, 1'b0, 1'b0, 32'h0000_1220, 64'd0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_1234, rep(8'h33),  256'd0, 1'b1, 1'b0, 1'b0, 32'h0000_1220, 64'd0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_1234, rep(8'h44),  256'd0, 1'b0, 1'b0, 1'b1, 32'h0000_1220, 64'd0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 64'd0,       256'd0, 1'b0, 1'b0, 1'b0, 32'h0000_1220, 64'd0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0000_ABCD, 64'd0,       wline,  1'b0, 1'b1, 1'b0, 32'h0000_ABC0, rep(8'hAA));
        vecs[7]  = mk(1'b0, 1'b1, 1'b1, 32'h0000_ABCD, 64'd0,       wline,  1'b0, 1'b1, 1'b0, 32'h0000_ABC0, rep(8'hBB));
        vecs[8]  = mk(1'b0, 1'b1, 1'b1, 32'h0000_ABCD, 64'd0,       wline,  1'b0, 1'b1, 1'b0, 32'h0000_ABC0, rep(8'hCC));
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 32'h0000_ABCD, 64'd0,       wline,  1'b0, 1'b1, 1'b0, 32'h0000_ABC0, rep(8'hDD));
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 32'h0000_ABCD, 64'd0,       wline,  1'b0, 1'b0, 1'b1, 32'h0000_ABC0, 64'd0);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 64'd0,       256'd0, 1'b0, 1'b0, 1'b0, 32'h0000_ABC0, 64'd0);

        // Reset state
        reset_n = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        line_i = 256'd0; address_i = 32'd0; burst_i = 64'd0;
        tick();
        tick();
        check_ports("reset", 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
        check("reset_line_o", line_o, 256'd0);
        reset_n = 1'b1;
        tick();

        // Table-driven read and write bursts
        for (int i = 0; i < 12; i++) begin
            read_i = vecs[i].rd; write_i = vecs[i].wr; resp_i = vecs[i].rsp;
            address_i = vecs[i].addr; burst_i = vecs[i].beat; line_i = vecs[i].line;
            tick();
            check_ports($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_rsp,
                        vecs[i].e_addr, vecs[i].e_burst);
            if (i == 5) begin
                check("read_line_o", line_o, {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)});
            end
        end

        // Stalled read: resp_i pattern 1,0,0,1,0,1,1
        read_i = 1'b1; address_i = 32'h0000_0100; resp_i = 1'b0;
        tick();
        check("stall_accept_read_o", {255'd0, read_o}, {255'd0, 1'b1});
        k_beat = 0;
        for (int i = 0; i < 7; i++) begin
            resp_i = (stall_pat[i] != 0);
            if (stall_pat[i] != 0) begin
                burst_i = stall_beats[k_beat];
                k_beat++;
            end else begin
                burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            tick();
            check($sformatf("stall%0d_resp_o", i), {255'd0, resp_o}, {255'd0, (i == 6)});
            check($sformatf("stall%0d_read_o", i), {255'd0, read_o}, {255'd0, (i != 6)});
        end
        read_i = 1'b0; resp_i = 1'b0; burst_i = 64'd0;
        tick();
        check("stall_after_resp_o", {255'd0, resp_o}, 256'd0);
        check("stall_line_o", line_o, {rep(8'h88), rep(8'h77), rep(8'h66), rep(8'h55)});

        // Asynchronous reset after two write beats
        write_i = 1'b1; address_i = 32'h2000_0040; line_i = wline2;
        tick();
        check("rst_wr_write_o", {255'd0, write_o}, {255'd0, 1'b1});
        check("rst_wr_address_o", {224'd0, address_o}, {224'd0, 32'h2000_0040});
        resp_i = 1'b1;
        tick();
        tick();
        check("rst_wr_burst_o", {192'd0, burst_o}, {192'd0, rep(8'h03)});
        #2;
        reset_n = 1'b0;
        #1;
        check_ports("rst_async", 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
        check("rst_async_line_o", line_o, 256'd0);
        write_i = 1'b0; resp_i = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check_ports("rst_release", 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);

        // Fresh read after reset; beats must land from slot 0
        read_i = 1'b1; address_i = 32'h0000_3FFF;
        tick();
        check("fresh_read_o", {255'd0, read_o}, {255'd0, 1'b1});
        check("fresh_address_o", {224'd0, address_o}, {224'd0, 32'h0000_3FE0});
        for (int i = 0; i < 4; i++) begin
            resp_i = 1'b1;
            burst_i = rep(8'h91 + 8'(i));
            tick();
            check($sformatf("fresh%0d_resp_o", i), {255'd0, resp_o}, {255'd0, (i == 3)});
        end
        read_i = 1'b0; resp_i = 1'b0; burst_i = 64'd0;
        tick();
        check("fresh_line_o", line_o, {rep(8'h94), rep(8'h93), rep(8'h92), rep(8'h91)});

        // Spurious resp_i in IDLE, then back-to-back read and write
        pulses = 0;
        resp_i = 1'b1; burst_i = rep(8'hEE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_ports($sformatf("spur%0d", i), 1'b0, 1'b0, 1'b0, 32'h0000_3FE0, 64'd0);
        end
        read_i = 1'b1; address_i = 32'h0000_4010;
        tick();
        check("b2b_read_o", {255'd0, read_o}, {255'd0, 1'b1});
        for (int i = 0; i < 4; i++) begin
            burst_i = rep(8'hC1 + 8'(i));
            tick();
            if (resp_o) pulses++;
            check($sformatf("b2b_rd%0d_resp_o", i), {255'd0, resp_o}, {255'd0, (i == 3)});
        end
        check("b2b_done_write_o", {255'd0, write_o}, 256'd0);
        tick();
        if (resp_o) pulses++;
        check_ports("b2b_idle", 1'b0, 1'b0, 1'b0, 32'h0000_4000, 64'd0);
        check("b2b_line_o", line_o, {rep(8'hC4), rep(8'hC3), rep(8'hC2), rep(8'hC1)});
        read_i = 1'b0; write_i = 1'b1; line_i = wline; address_i = 32'h0000_5000;
        tick();
        if (resp_o) pulses++;
        check("b2b_write_o", {255'd0, write_o}, {255'd0, 1'b1});
        check("b2b_wr_burst_o", {192'd0, burst_o}, {192'd0, rep(8'hAA)});
        prev_resp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (prev_resp) write_i = 1'b0;
            tick();
            if (resp_o) pulses++;
            check($sformatf("b2b_wr%0d_resp_o", k), {255'd0, resp_o}, {255'd0, (k == 3)});
            if (k < 3) begin
                check($sformatf("b2b_wr%0d_burst_o", k), {192'd0, burst_o},
                      {192'd0, rep(8'hBB + 8'h11 * 8'(k))});
            end
            prev_resp = resp_o;
        end
        resp_i = 1'b0;
        check("b2b_pulses", 256'(pulses), 256'd2);
        check("no_illegal_request", {255'd0, illegal_seen}, 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_burst_adaptor.md
Name: line_burst_adaptor

Overview:
- Converts one 256-bit cacheline transaction from the memory arbiter into a 4-beat, 64-bit burst on the physical memory port, and the reverse.
- Sits directly downstream of the instruction/data memory arbiter and directly upstream of physical memory.
- Holds one transaction at a time. Completion is signalled to the arbiter with a single-cycle resp_o.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- BURST_WIDTH, 64, physical memory beat width in bits. BEATS = LINE_WIDTH/BURST_WIDTH = 4.
- ADDR_WIDTH, 32, address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- line_i  input  LINE_WIDTH  write line from the arbiter.
- line_o  output  LINE_WIDTH  assembled read line to the arbiter.
- address_i  input  ADDR_WIDTH  line address from the arbiter.
- read_i  input  1  line read request; held until resp_o.
- write_i  input  1  line write request; held until resp_o.
- resp_o  output  1  transaction complete; one-cycle pulse.
- burst_i  input  BURST_WIDTH  read beat from physical memory.
- burst_o  output  BURST_WIDTH  write beat to physical memory.
- address_o  output  ADDR_WIDTH  line-aligned address to physical memory.
- read_o  output  1  burst read request.
- write_o  output  1  burst write request.
- resp_i  input  1  physical memory beat strobe; one beat per high cycle.

Behaviour:
- **Reset** (reset_n low, asynchronous):
  - state=IDLE, beat counter=0.
  - line_o, burst_o, address_o, resp_o, read_o, write_o all 0.
  - Reset mid-burst abandons the transaction immediately. No resp_o is issued.
- **States**: IDLE, READ, WRITE, DONE. All outputs are registered or decoded from registered state; there is no combinational path from any input to any output.
- **IDLE**:
  - If read_i: latch address_i, go to READ.
  - Else if write_i: latch address_i and line_i, go to WRITE.
  - Read has priority when read_i and write_i are both high; that combination is illegal upstream, and the bench flags it.
  - resp_i is ignored in IDLE.
- **Address**: address_o = {latched address[ADDR_WIDTH-1:5], 5'b0}. The low offset bits are always cleared. address_o is stable from the first READ/WRITE cycle through DONE.
- **READ**:
  - read_o=1.
  - Each cycle resp_i=1: store burst_i into line bits [64*cnt+63 : 64*cnt], then cnt++.
  - Beats may be non-consecutive. Cycles with resp_i=0 hold cnt and data.
  - On the beat with cnt==3: go to DONE, cnt wraps to 0.
  - read_o drops in the DONE cycle.
- **WRITE**:
  - write_o=1 and burst_o = latched line beat[cnt] at all times in WRITE.
  - Each resp_i=1 cycle consumes the current beat, then cnt++.
  - On the beat with cnt==3: go to DONE.
  - write_o drops in DONE. burst_o returns to 0 in DONE.
- **DONE**:
  - resp_o=1 for exactly this one cycle. line_o holds the assembled line (read) and remains stable until the next read's first beat.
  - Next state is IDLE unconditionally. read_i/write_i and resp_i are ignored in DONE.
  - The arbiter deasserts its request in the cycle after resp_o.
- **Latency**:
  - Request sampled in IDLE at cycle T. read_o/write_o high at T+1.
  - With memory responding immediately on T+1..T+4, resp_o is high at T+5.
- **Spurious resp_i**: resp_i outside READ/WRITE has no effect. cnt never exceeds 3.
- **Back-to-back**: a new request is accepted no earlier than the IDLE cycle following DONE.

Test Plan:
- **Read**: read_i=1, address_i=0x0000_1234. Memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i cycles. Required:
  - address_o=0x0000_1220 with read_o high for 4 cycles.
  - resp_o pulses once, the cycle after the 4th beat.
  - line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- **Write**: write_i=1, line_i = {0xDDDD.., 0xCCCC.., 0xBBBB.., 0xAAAA..}. Required:
  - burst_o sequence is 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.., one per resp_i.
  - write_o drops and resp_o=1 in the cycle after the 4th beat.
- **Stalled beats**: read with resp_i pattern 1,0,0,1,0,1,1. Required:
  - Beats land in slots 0..3 in order.
  - resp_o arrives the cycle after the last resp_i, exactly one pulse.
- **Reset mid-burst**: assert reset_n=0 asynchronously after 2 write beats. Required:
  - read_o, write_o, resp_o and address_o are 0 immediately, before the next clock edge.
  - After release, a fresh read completes normally with cnt restarting at 0.
- **Back-to-back and spurious**: resp_i=1 while IDLE, then read then write issued with no gap cycles upstream. Required:
  - The spurious resp_i produces no resp_o or state change.
  - The write is accepted only in IDLE after the read's DONE.
  - Exactly two resp_o pulses total.
